// File: rtl/ram_writer_pkg.sv
`default_nettype none
// ==========================================================================
// ram_writer_pkg : FSM states, command encodings and default geometry
// Rev 1.0
// ==========================================================================
package ram_writer_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DEPTH_DEF  = 4096;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  localparam int          CMD_SETADDR = 15;
  localparam logic [15:0] CMD_RESTART = 16'h0001;

  function automatic logic is_restart(input logic [15:0] w);
    return (w == CMD_RESTART);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_writer_addr_ctr.sv
`default_nettype none
// ==========================================================================
// addr_ctr : frame address counter with load, increment and wrap
// Rev 1.0
// ==========================================================================
module addr_ctr
  import ram_writer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              inc_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  output logic [ADDR_W-1:0] next_o,
  output logic              wrap_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] count_d;

  assign wrap_o = inc_i && (count_q == LAST);

  // A load lands after a simultaneous increment, so it wins.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + ADDR_W'(1);
    end
  end

  assign next_o = count_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_writer.sv
`default_nettype none
// ==========================================================================
// ram_writer : streams SPI words into a frame RAM, decodes address commands
// Optional checksum output when RAM_WRITER_CKSUM_EN is defined. Rev 1.0
// ==========================================================================
module ram_writer
  import ram_writer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [15:0]       Data_RAM,
  input  logic              Mode,
  input  logic              i_RAM_valid,
  output logic              o_RAM_ready,
  input  logic              i_mem_busy,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  output logic              o_frame_done
`ifdef RAM_WRITER_CKSUM_EN
  ,
  output logic [15:0]       o_cksum
`endif
);

  localparam logic [31:0] LAST_W    = 32'(DEPTH - 1);
  localparam logic [31:0] ADDR_MASK = (ADDR_W >= 15) ? 32'h0000_7FFF
                                                     : ((32'd1 << ADDR_W) - 32'd1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;

  logic              accept, data_acc, cmd_acc, complete;
  logic              set_addr, restart, wrap;
  logic [31:0]       cmd_addr;
  logic [ADDR_W-1:0] ld_val, ctr_next;

  assign accept   = i_RAM_valid && o_RAM_ready;
  assign data_acc = accept && !Mode;
  assign cmd_acc  = accept && Mode;
  assign complete = o_wr_en && !i_mem_busy;
  assign set_addr = cmd_acc && Data_RAM[CMD_SETADDR];
  assign restart  = cmd_acc && is_restart(Data_RAM);

  always_comb begin
    cmd_addr = {17'd0, Data_RAM[14:0]} & ADDR_MASK;
    ld_val   = '0;
    if (set_addr) begin
      ld_val = (cmd_addr > LAST_W) ? LAST_W[ADDR_W-1:0] : cmd_addr[ADDR_W-1:0];
    end
  end

  addr_ctr #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_ctr (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .inc_i      (complete),
    .load_i     (set_addr || restart),
    .load_val_i (ld_val),
    .next_o     (ctr_next),
    .wrap_o     (wrap)
  );

  assign o_wr_en      = (state_q == S_WRITE) || (state_q == S_HOLD);
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_frame_done = wrap;

  always_comb begin
    o_RAM_ready = 1'b0;
    state_d     = state_q;
    case (state_q)
      S_IDLE: begin
        o_RAM_ready = 1'b1;
        if (data_acc) state_d = S_WRITE;
      end
      S_WRITE: begin
        o_RAM_ready = !i_mem_busy;
        if (i_mem_busy)    state_d = S_HOLD;
        else if (data_acc) state_d = S_WRITE;
        else               state_d = S_IDLE;
      end
      S_HOLD: begin
        if (!i_mem_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ctr_next already includes the increment of a write completing this cycle.
  always_comb begin
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (data_acc) begin
      wr_addr_d = ctr_next;
      wr_data_d = Data_RAM;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef RAM_WRITER_CKSUM_EN
  logic [15:0] cksum_q, cksum_d;
  logic        clr_q, clr_d;

  // A wrap arms clr_q so the finished frame's sum stays visible until the next word.
  always_comb begin
    cksum_d = cksum_q;
    clr_d   = clr_q;
    if (restart) begin
      cksum_d = '0;
      clr_d   = 1'b0;
    end else if (complete) begin
      cksum_d = (clr_q ? 16'd0 : cksum_q) + wr_data_q;
      clr_d   = wrap;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cksum_q <= '0;
      clr_q   <= 1'b0;
    end else begin
      cksum_q <= cksum_d;
      clr_q   <= clr_d;
    end
  end

  assign o_cksum = cksum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_writer.sv
`default_nettype none
// ==========================================================================
// tb_ram_writer : directed bench for ram_writer (default and DEPTH=4 builds)
// Rev 1.0
// ==========================================================================
module tb_ram_writer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] Data_RAM;
  logic        Mode;
  logic        valid;
  logic        busy;

  logic        ready, wr_en, fd;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic        ready4, wr_en4, fd4;
  logic [11:0] wr_addr4;
  logic [15:0] wr_data4;
`ifdef RAM_WRITER_CKSUM_EN
  logic [15:0] cksum, cksum4;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  ram_writer dut (
    .CLK (CLK), .RST_N (RST_N), .Data_RAM (Data_RAM), .Mode (Mode),
    .i_RAM_valid (valid), .o_RAM_ready (ready), .i_mem_busy (busy),
    .o_wr_en (wr_en), .o_wr_addr (wr_addr), .o_wr_data (wr_data),
    .o_frame_done (fd)
`ifdef RAM_WRITER_CKSUM_EN
    , .o_cksum (cksum)
`endif
  );

  ram_writer #(.ADDR_W (12), .DEPTH (4)) dut4 (
    .CLK (CLK), .RST_N (RST_N), .Data_RAM (Data_RAM), .Mode (Mode),
    .i_RAM_valid (valid), .o_RAM_ready (ready4), .i_mem_busy (busy),
    .o_wr_en (wr_en4), .o_wr_addr (wr_addr4), .o_wr_data (wr_data4),
    .o_frame_done (fd4)
`ifdef RAM_WRITER_CKSUM_EN
    , .o_cksum (cksum4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    RST_N = 1'b0; valid = 1'b0; busy = 1'b0; Mode = 1'b0; Data_RAM = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    automatic logic [11:0] exp4_addr[5] = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd0};
    automatic logic        exp4_fd[5]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    RST_N = 1'b0; valid = 1'b0; busy = 1'b0; Mode = 1'b0; Data_RAM = '0;
    repeat (2) @(negedge CLK);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_fd", fd, 0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("ready_after_rst", ready, 1);

    // Three back-to-back data words
    valid = 1'b1; Data_RAM = 16'h0011;
    @(negedge CLK);
    chk("b2b0_en", wr_en, 1); chk("b2b0_addr", wr_addr, 0); chk("b2b0_data", wr_data, 16'h0011);
    Data_RAM = 16'h0022;
    @(negedge CLK);
    chk("b2b1_en", wr_en, 1); chk("b2b1_addr", wr_addr, 1); chk("b2b1_data", wr_data, 16'h0022);
    Data_RAM = 16'h0033;
    @(negedge CLK);
    chk("b2b2_en", wr_en, 1); chk("b2b2_addr", wr_addr, 2); chk("b2b2_data", wr_data, 16'h0033);
    valid = 1'b0;
    @(negedge CLK);
    chk("b2b_idle_en", wr_en, 0); chk("b2b_idle_ready", ready, 1);

    // Write stalled by busy for three cycles
    valid = 1'b1; Data_RAM = 16'hABCD;
    @(negedge CLK);
    valid = 1'b0; busy = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_en", wr_en, 1); chk("hold_addr", wr_addr, 3);
      chk("hold_data", wr_data, 16'hABCD); chk("hold_ready", ready, 0);
      @(negedge CLK);
    end
    busy = 1'b0;
    #1;
    chk("hold4_en", wr_en, 1); chk("hold4_addr", wr_addr, 3);
    chk("hold4_data", wr_data, 16'hABCD); chk("hold4_ready", ready, 0);
    @(negedge CLK);
    chk("hold_done_en", wr_en, 0); chk("hold_done_ready", ready, 1);
    valid = 1'b1; Data_RAM = 16'h5555;
    @(negedge CLK);
    chk("after_hold_addr", wr_addr, 4); chk("after_hold_data", wr_data, 16'h5555);
    valid = 1'b0;
    @(negedge CLK);

    // Restart, set-address, discarded command
    valid = 1'b1; Mode = 1'b1; Data_RAM = 16'h0001;
    @(negedge CLK);
    chk("restart_no_wr", wr_en, 0); chk("restart_no_fd", fd, 0);
    Mode = 1'b0; Data_RAM = 16'hBEEF;
    @(negedge CLK);
    chk("restart_addr", wr_addr, 0); chk("restart_data", wr_data, 16'hBEEF);
    Mode = 1'b1; Data_RAM = 16'h8005;
    @(negedge CLK);
    chk("setaddr_no_wr", wr_en, 0);
    Mode = 1'b0; Data_RAM = 16'h1234;
    @(negedge CLK);
    chk("setaddr_addr", wr_addr, 5); chk("setaddr_data", wr_data, 16'h1234);
    chk("sat4_addr", wr_addr4, 3);
    Mode = 1'b1; Data_RAM = 16'h0002;
    @(negedge CLK);
    chk("discard_no_wr", wr_en, 0);
    Mode = 1'b0; Data_RAM = 16'h7777;
    @(negedge CLK);
    chk("discard_addr", wr_addr, 6);

    // Command accepted while a write is pending
    Data_RAM = 16'h1111;
    @(negedge CLK);
    chk("pend_addr", wr_addr, 7);
    Mode = 1'b1; Data_RAM = 16'h8009;
    @(negedge CLK);
    chk("pend_cmd_no_wr", wr_en, 0); chk("pend_addr_kept", wr_addr, 7);
    Mode = 1'b0; Data_RAM = 16'h2222;
    @(negedge CLK);
    chk("pend_next_addr", wr_addr, 9);
    valid = 1'b0;
    @(negedge CLK);

    // Frame wrap on the DEPTH=4 instance
    pulse_reset();
    valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      Data_RAM = 16'(i + 1);
      @(negedge CLK);
      chk("wrap_addr", wr_addr4, exp4_addr[i]);
      chk("wrap_data", wr_data4, 16'(i + 1));
      chk("wrap_fd", fd4, exp4_fd[i]);
      chk("wrap_fd_big", fd, 0);
    end
    valid = 1'b0;
    #1;
    chk("wrap_last_fd", fd4, 0);
    @(negedge CLK);
    chk("wrap_idle_en", wr_en4, 0);

    // Asynchronous reset while held
    valid = 1'b1; Mode = 1'b1; Data_RAM = 16'h8007;
    @(negedge CLK);
    Mode = 1'b0; Data_RAM = 16'hCAFE;
    @(negedge CLK);
    valid = 1'b0; busy = 1'b1;
    @(negedge CLK);
    chk("areset_pre_en", wr_en, 1); chk("areset_pre_addr", wr_addr, 7);
    RST_N = 1'b0;
    #1;
    chk("areset_en", wr_en, 0); chk("areset_addr", wr_addr, 0);
    chk("areset_data", wr_data, 0); chk("areset_fd", fd, 0);
    @(negedge CLK);
    RST_N = 1'b1; busy = 1'b0;
    #1;
    chk("areset_ready", ready, 1);
    valid = 1'b1; Data_RAM = 16'h0BAD;
    @(negedge CLK);
    chk("areset_next_en", wr_en, 1); chk("areset_next_addr", wr_addr, 0);
    chk("areset_next_data", wr_data, 16'h0BAD);
    valid = 1'b0;
    @(negedge CLK);

`ifdef RAM_WRITER_CKSUM_EN
    pulse_reset();
    chk("cksum_rst", cksum, 0);
    valid = 1'b1; Data_RAM = 16'hFFFF;
    @(negedge CLK);
    Data_RAM = 16'h0002;
    @(negedge CLK);
    valid = 1'b0;
    @(negedge CLK);
    chk("cksum_sum", cksum, 16'h0001);
    valid = 1'b1; Mode = 1'b1; Data_RAM = 16'h0001;
    @(negedge CLK);
    valid = 1'b0; Mode = 1'b0;
    chk("cksum_restart", cksum, 0);
    @(negedge CLK);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_writer.md
RAM_WRITER -- requirements
Module: ram_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: width of the RAM write address.
REQ-002 SHALL have parameter DEPTH, default 4096: number of words per frame; 2 <= DEPTH <= 2**ADDR_W.
REQ-003 SHALL have port CLK, input, 1: the single clock, rising-edge.
REQ-004 SHALL have port RST_N, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port Data_RAM, input, 16: word from the SPI packing stage.
REQ-006 SHALL have port Mode, input, 1: 0 = pixel/data word, 1 = command word.
REQ-007 SHALL have port i_RAM_valid, input, 1: Data_RAM/Mode are valid.
REQ-008 SHALL have port o_RAM_ready, output, 1: block accepts a word this cycle.
REQ-009 SHALL have port i_mem_busy, input, 1: RAM cannot take a write this cycle.
REQ-010 SHALL have port o_wr_en, output, 1: RAM write strobe.
REQ-011 SHALL have port o_wr_addr, output, ADDR_W: RAM write address.
REQ-012 SHALL have port o_wr_data, output, 16: RAM write data.
REQ-013 SHALL have port o_frame_done, output, 1: one-cycle pulse on frame completion.

Function
REQ-014 SHALL transfer a word only on a rising CLK edge where i_RAM_valid and o_RAM_ready are both 1.
REQ-015 SHALL use FSM states S_IDLE (no write pending), S_WRITE (o_wr_en=1) and S_HOLD (write stalled by i_mem_busy).
REQ-016 SHALL drive o_RAM_ready = 1 in S_IDLE, = !i_mem_busy in S_WRITE, and = 0 in S_HOLD.
REQ-017 SHALL, on transfer of a data word (Mode=0), register it to o_wr_data and o_wr_addr = current address, entering S_WRITE the next cycle (latency 1).
REQ-018 SHALL, in S_WRITE with i_mem_busy=1, go to S_HOLD with o_wr_en, o_wr_addr and o_wr_data held stable until i_mem_busy=0.
REQ-019 SHALL, on S_WRITE/S_HOLD completion with a new transfer in the same cycle, stay in S_WRITE with the new word (back-to-back, one word per cycle).
REQ-020 SHALL increment the address counter on each completed write; from DEPTH-1 it SHALL wrap to 0 and pulse o_frame_done for exactly one cycle.
REQ-021 SHALL treat command word 16'h8000|A (Mode=1, bit15=1) as set-address: counter <= A[ADDR_W-1:0], saturated to DEPTH-1; no write issued.
REQ-022 SHALL treat command 16'h0001 (Mode=1) as frame restart: counter <= 0, no write, no o_frame_done.
REQ-023 SHALL accept and discard all other command words with no state change.
REQ-024 SHALL apply a command accepted while a write is pending after that write completes, so the pending write keeps its original address.

Reset
REQ-025 SHALL, on RST_N=0 (asynchronous, even mid-write), force S_IDLE, counter 0, o_wr_en 0, o_wr_addr 0, o_wr_data 0, o_frame_done 0.
REQ-026 SHALL drive o_RAM_ready 1 in the first cycle after RST_N deasserts.

Configuration
REQ-027 SHALL, with RAM_WRITER_CKSUM_EN defined, add output o_cksum[15:0]: a modulo-2^16 running sum of written data words, cleared by reset, frame restart and wrap; the wrap clear takes effect after the final word is added.
REQ-028 SHALL, without RAM_WRITER_CKSUM_EN, have no o_cksum port and no checksum logic.

Structure
REQ-029 SHALL place the FSM state enum, the command encodings (CMD_SETADDR bit, CMD_RESTART=16'h0001) and the default ADDR_W/DEPTH in shared package ram_writer_pkg.
REQ-030 SHALL be a single module; the address counter MAY be sub-module addr_ctr (load, increment, wrap, frame_done).

Verification
REQ-031 SHALL be verified by: reset, then 3 data words 16'h0011, 16'h0022, 16'h0033 back-to-back with i_mem_busy=0 -> writes at addresses 0, 1, 2 on consecutive cycles, each 1 cycle after acceptance.
REQ-032 SHALL be verified by: i_mem_busy=1 for 3 cycles during a write of 16'hABCD -> o_wr_en/addr/data stable for 4 cycles, o_RAM_ready 0 while held, no word lost.
REQ-033 SHALL be verified by: with DEPTH=4, 5 data words -> addresses 0, 1, 2, 3, 0; o_frame_done pulses once, in the cycle of the address-3 write completing.
REQ-034 SHALL be verified by: command 16'h8005 then data 16'h1234 -> write at address 5; command 16'h0001 then data -> write at address 0.
REQ-035 SHALL be verified by: RST_N pulsed low while in S_HOLD -> all outputs 0 immediately; the next accepted word is written at address 0.
REQ-036 SHALL be verified by, with RAM_WRITER_CKSUM_EN: data words 16'hFFFF and 16'h0002 -> o_cksum = 16'h0001.
